chino_uart_tx: RTL and testbench
================================

CHINO_UART_TX -- requirements
Module: chino_uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the TX FIFO entry count (power of two).
REQ-002 SHALL have parameter DIV_RESET, default 16'd868, giving the reset value of BAUDDIV.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port ce_i, input, 1 bit: data-bus chip enable from the CPU.
REQ-006 SHALL have port we_i, input, 1 bit: write enable, valid with ce_i.
REQ-007 SHALL have port addr_i, input, 32 bits: byte address; only addr_i[3:2] is decoded.
REQ-008 SHALL have port sel_i, input, 4 bits: byte lane selects.
REQ-009 SHALL have port data_i, input, 32 bits: write data.
REQ-010 SHALL have port data_o, output, 32 bits: read data.
REQ-011 SHALL have port tx_o, output, 1 bit: serial line; idle high.
REQ-012 SHALL have port irq_o, output, 1 bit: level interrupt to the CPU int_i vector.

Function
REQ-013 Register map by addr_i[3:2] SHALL be: 0 TXDATA, 1 STATUS, 2 BAUDDIV, 3 CTRL.
REQ-014 A write SHALL take effect at the rising edge where ce_i=1 and we_i=1.
REQ-015 data_o SHALL be combinational from addr_i when ce_i=1 and we_i=0, and 0 otherwise.
REQ-016 A TXDATA write with sel_i[0]=1 SHALL push data_i[7:0]; TXDATA SHALL read as 0.
REQ-017 STATUS read layout SHALL be: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bits5:3 count, bit6 overflow; all other bits 0.
REQ-018 STATUS bit6 SHALL be cleared by a STATUS write with sel_i[0]=1 and data_i[6]=1 (W1C); other STATUS bits SHALL ignore writes.
REQ-019 BAUDDIV[15:0] SHALL be writable per byte via sel_i[1:0]; an effective divisor of 0 SHALL be treated as 1.
REQ-020 CTRL bit0 tx_en and bit1 irq_en SHALL be written when sel_i[0]=1; both SHALL reset to 0.
REQ-021 A push SHALL be accepted if count<FIFO_DEPTH or a pop occurs in the same cycle.
REQ-022 A push to a full FIFO with no simultaneous pop SHALL be dropped and SHALL set overflow.
REQ-023 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-024 From IDLE, if tx_en=1 and the FIFO is non-empty, the FSM SHALL pop the head byte into the shift register and enter START at the next edge.
REQ-025 Frame format SHALL be 8N1, LSB first; each bit SHALL last exactly BAUDDIV clk cycles.
REQ-026 Transitions SHALL be START->DATA after one bit time, DATA->STOP after 8 bits, and STOP->IDLE after one bit time.
REQ-027 tx_o SHALL be 0 in START, the shift LSB in DATA, and 1 in IDLE and STOP.
REQ-028 A BAUDDIV write mid-frame SHALL apply from the next bit boundary.
REQ-029 Clearing tx_en mid-frame SHALL let the current frame complete; no further pop SHALL occur.
REQ-030 Back-to-back frames SHALL be produced as STOP->IDLE->START with one idle-high cycle between frames.
REQ-031 irq_o SHALL equal irq_en AND FIFO empty AND FSM in IDLE, registered (one cycle after the condition).

Reset
REQ-032 On rst=0 at a clock edge: FIFO emptied, overflow=0, tx_en=0, irq_en=0, BAUDDIV=DIV_RESET, FSM=IDLE, bit counters=0.
REQ-033 Outputs after reset SHALL be tx_o=1 and irq_o=0; data_o follows REQ-015 and reads the reset values.
REQ-034 Reset mid-frame SHALL abort the frame, with tx_o=1 from the next edge.

Structure
REQ-035 Register offsets, STATUS bit positions, and FSM state encodings SHALL be macros in defines.v.
REQ-036 The FIFO SHALL be a sub-module chino_sync_fifo (parameterised width/depth, push/pop/full/empty/count).
REQ-037 chino_uart_tx SHALL attach in chino_min_sopc alongside data_ram, selected by upper-address decode external to this block.

Verification
REQ-038 Reset check: reset, then read STATUS -> 0x00000004; read BAUDDIV -> 0x00000364; tx_o=1; irq_o=0.
REQ-039 Single frame: BAUDDIV=4, CTRL=1, write TXDATA 0x55 at edge N -> tx_o=0 over cycles N+1..N+4, then data bits 1,0,1,0,1,0,1,0, each 4 cycles, stop high, busy=0 at N+41.
REQ-040 Overflow: tx_en=0, write 5 bytes -> STATUS full=1, count=4, overflow=1; W1C 0x40 -> overflow=0, full still 1.
REQ-041 Push while popping when full: full FIFO, set tx_en, push at the pop edge -> push accepted, count stays 4, no overflow.
REQ-042 Interrupt: CTRL=3, send one byte -> irq_o=0 during the frame, =1 one cycle after return to IDLE.
REQ-043 Mid-frame reset: assert rst during DATA -> tx_o=1 next edge; STATUS reads 0x00000004.

Source files
------------

// File: rtl/chino_uart_tx_pkg.sv
// chino_uart_tx shared definitions: register offsets,
// STATUS bit positions, FSM states, divisor helper.
package chino_uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_CNT   = 3;
  localparam int ST_OVF   = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // A programmed divisor of 0 behaves as 1.
  function automatic logic [15:0] eff_div(
    input logic [15:0] d
  );
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/chino_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, head visible on data_o.
// Ports: clk, rst_ni (sync low), push_i/data_i, pop_i, data_o, full_o, empty_o, count_o.
module chino_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // A full FIFO still takes a push when the head leaves
  // in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/chino_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and irq.
// Ports: clk, rst (sync low), ce_i/we_i/addr_i/sel_i/data_i bus in, data_o, tx_o, irq_o.
module chino_uart_tx #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o
);

  import chino_uart_tx_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    reg_sel;
  logic          wr_en, rd_en;
  logic          push, pop, drop;
  logic [7:0]    head;
  logic          full, empty;
  logic [CW-1:0] count;
  logic [31:0]   status;
  logic [15:0]   div_eff;

  logic          tx_en_q, tx_en_d;
  logic          irq_en_q, irq_en_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;
  logic [15:0]   div_q, div_d;

  tx_state_e     state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          bit_end;

  logic          unused_bits;
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0],
                         data_i[31:16], sel_i[3:2]};

  assign reg_sel = addr_i[3:2];
  assign wr_en   = ce_i & we_i;
  assign rd_en   = ce_i & ~we_i;
  assign push    = wr_en & (reg_sel == REG_TXDATA) & sel_i[0];
  assign drop    = push & full & ~pop;
  assign div_eff = eff_div(div_q);
  assign bit_end = (cnt_q == 16'd0);
  assign irq_o   = irq_q;

  chino_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (data_i[7:0]),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    div_d    = div_q;
    ovf_d    = ovf_q | drop;
    if (wr_en) begin
      unique case (reg_sel)
        REG_TXDATA: ;
        REG_STATUS: begin
          if (sel_i[0] && data_i[ST_OVF])
            ovf_d = 1'b0;
        end
        REG_BAUDDIV: begin
          if (sel_i[0]) div_d[7:0]  = data_i[7:0];
          if (sel_i[1]) div_d[15:8] = data_i[15:8];
        end
        REG_CTRL: begin
          if (sel_i[0]) begin
            tx_en_d  = data_i[0];
            irq_en_d = data_i[1];
          end
        end
      endcase
    end
    irq_d = irq_en_q & empty & (state_q == S_IDLE);
  end

  always_comb begin
    status            = '0;
    status[ST_BUSY]   = (state_q != S_IDLE);
    status[ST_FULL]   = full;
    status[ST_EMPTY]  = empty;
    status[ST_CNT+:3] = 3'(count);
    status[ST_OVF]    = ovf_q;
  end

  always_comb begin
    data_o = '0;
    if (rd_en) begin
      unique case (reg_sel)
        REG_TXDATA:  data_o = '0;
        REG_STATUS:  data_o = status;
        REG_BAUDDIV: data_o = {16'h0, div_q};
        REG_CTRL:    data_o = {30'h0, irq_en_q, tx_en_q};
      endcase
    end
  end

  // The bit counter is loaded from BAUDDIV only at a bit
  // start, so a divisor change lands on the next boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tx_en_q && !empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = div_eff - 16'd1;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = div_eff - 16'd1;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = div_eff - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
        else         cnt_d   = cnt_q - 16'd1;
      end
    endcase
  end

  always_comb begin
    unique case (state_q)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = shift_q[0];
      default: tx_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      div_q    <= DIV_RESET;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else begin
      tx_en_q  <= tx_en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      div_q    <= div_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

endmodule

// File: tb/tb_chino_uart_tx.sv
// Self-checking bench for chino_uart_tx: register table,
// timed frame sequences and random frames vs. a line model.
module tb_chino_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        tx_o;
  logic        irq_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] A_TX = 2'd0;
  localparam logic [1:0] A_ST = 2'd1;
  localparam logic [1:0] A_BD = 2'd2;
  localparam logic [1:0] A_CT = 2'd3;

  always #5 clk = ~clk;

  chino_uart_tx #(
    .FIFO_DEPTH (4),
    .DIV_RESET  (16'd868)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ce_i   (ce_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .sel_i  (sel_i),
    .data_i (data_i),
    .data_o (data_o),
    .tx_o   (tx_o),
    .irq_o  (irq_o)
  );

  typedef struct {
    bit          c;
    bit          w;
    logic [1:0]  a;
    logic [3:0]  s;
    logic [31:0] d;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input bit c, input bit w, input logic [1:0] a,
    input logic [3:0] s, input logic [31:0] d,
    input bit chk, input logic [31:0] exp
  );
    vec_t v;
    v.c = c; v.w = w; v.a = a; v.s = s;
    v.d = d; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, got, exp);
    end
  endtask

  task automatic drive(input logic c, input logic w,
                       input logic [1:0] a,
                       input logic [3:0] s,
                       input logic [31:0] d);
    logic [31:0] r;
    r = $urandom;
    ce_i   = c;
    we_i   = w;
    addr_i = {r[31:4], a, r[1:0]};
    sel_i  = s;
    data_i = d;
  endtask

  task automatic idle();
    ce_i = 1'b0; we_i = 1'b0; sel_i = '0; data_i = '0;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [3:0] s,
                    input logic [31:0] d);
    drive(1'b1, 1'b1, a, s, d);
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input logic [1:0] a,
                    output logic [31:0] v);
    drive(1'b1, 1'b0, a, 4'hF, $urandom);
    #1 v = data_o;
    idle();
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_run(input logic [15:0] dv, input int nb);
    logic [7:0] expq[$];
    int eff;
    eff = (dv == 16'd0) ? 1 : int'(dv);
    reset_dut();
    wr(A_BD, 4'h3, {16'h0, dv});
    wr(A_CT, 4'h1, 32'h1);
    fork
      begin
        for (int k = 0; k < nb; k++) begin
          logic [31:0] st;
          logic [7:0]  b;
          int          guard;
          repeat (($urandom_range(0, 2) == 0) ?
                  $urandom_range(0, 12 * eff) : 0)
            @(negedge clk);
          guard = 0;
          rd(A_ST, st);
          while (st[1] && guard < 5000) begin
            @(negedge clk);
            rd(A_ST, st);
            guard++;
          end
          b = 8'($urandom);
          expq.push_back(b);
          wr(A_TX, 4'h1, {24'h0, b});
        end
      end
      begin
        for (int f = 0; f < nb; f++) begin
          int         w;
          int         bad;
          logic [7:0] got;
          logic [7:0] e;
          w = 0; bad = 0; got = '0;
          @(negedge clk);
          while (tx_o !== 1'b0 && w < 20000) begin
            @(negedge clk);
            w++;
          end
          if (w >= 20000) begin
            check("start_timeout", 32'd1, 32'd0);
            break;
          end
          if (expq.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
            break;
          end
          e = expq.pop_front();
          for (int k = 0; k < 10 * eff; k++) begin
            int   fb;
            logic x;
            fb = k / eff;
            if (k > 0) @(negedge clk);
            if (fb == 0)      x = 1'b0;
            else if (fb == 9) x = 1'b1;
            else              x = e[fb-1];
            if (tx_o !== x) bad++;
            if (fb >= 1 && fb <= 8 &&
                k == fb * eff + eff / 2)
              got[fb-1] = tx_o;
          end
          check("frame_shape", bad, 0);
          check("frame_byte", {24'h0, got}, {24'h0, e});
          @(negedge clk);
          check("gap_idle", {31'h0, tx_o}, 32'h1);
        end
      end
    join
    check("queue_drained", expq.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  b55;
    int          hi;

    b55 = 8'h55;
    reset_dut();

    check("rst_tx", {31'h0, tx_o}, 32'h1);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    rd(A_ST, v); check("rst_status", v, 32'h4);
    rd(A_BD, v); check("rst_baud", v, 32'h364);

    tbl.push_back(mk(1, 0, A_ST, 4'hF, 0, 1, 32'h4));
    tbl.push_back(mk(1, 0, A_BD, 4'hF, 0, 1, 32'h364));
    tbl.push_back(mk(1, 0, A_CT, 4'hF, 0, 1, 32'h0));
    tbl.push_back(mk(1, 0, A_TX, 4'hF, 0, 1, 32'h0));
    tbl.push_back(mk(0, 0, A_ST, 4'hF, 0, 1, 32'h0));
    tbl.push_back(mk(1, 1, A_BD, 4'h1, 32'hFFFF00AB, 0, 0));
    tbl.push_back(mk(1, 0, A_BD, 4'hF, 0, 1, 32'h3AB));
    tbl.push_back(mk(1, 1, A_BD, 4'h2, 32'h00001200, 0, 0));
    tbl.push_back(mk(1, 0, A_BD, 4'hF, 0, 1, 32'h12AB));
    tbl.push_back(mk(1, 1, A_BD, 4'hC, 32'hFFFFFFFF, 0, 0));
    tbl.push_back(mk(1, 0, A_BD, 4'hF, 0, 1, 32'h12AB));
    tbl.push_back(mk(1, 1, A_CT, 4'h1, 32'hFFFFFFFE, 0, 0));
    tbl.push_back(mk(1, 0, A_CT, 4'hF, 0, 1, 32'h2));
    tbl.push_back(mk(1, 1, A_CT, 4'hE, 32'hFFFFFFFF, 0, 0));
    tbl.push_back(mk(1, 0, A_CT, 4'hF, 0, 1, 32'h2));
    tbl.push_back(mk(1, 1, A_ST, 4'hF, 32'hFFFFFFFF, 0, 0));
    tbl.push_back(mk(1, 0, A_ST, 4'hF, 0, 1, 32'h4));
    tbl.push_back(mk(1, 1, A_TX, 4'hE, 32'h11, 0, 0));
    tbl.push_back(mk(1, 0, A_ST, 4'hF, 0, 1, 32'h4));
    tbl.push_back(mk(1, 1, A_TX, 4'h1, 32'h22, 0, 0));
    tbl.push_back(mk(1, 0, A_ST, 4'hF, 0, 1, 32'h8));
    tbl.push_back(mk(1, 1, A_CT, 4'h1, 32'h0, 0, 0));

    foreach (tbl[i]) begin
      if (tbl[i].c && tbl[i].w) begin
        wr(tbl[i].a, tbl[i].s, tbl[i].d);
      end else begin
        drive(tbl[i].c, 1'b0, tbl[i].a, tbl[i].s, tbl[i].d);
        #1;
        if (tbl[i].chk)
          check($sformatf("tbl[%0d]", i), data_o, tbl[i].exp);
        idle();
        @(negedge clk);
      end
    end

    // Single 0x55 frame with exact cycle positions.
    reset_dut();
    wr(A_BD, 4'h3, 32'd4);
    wr(A_CT, 4'h1, 32'h1);
    wr(A_TX, 4'h1, 32'h55);
    for (int i = 1; i <= 41; i++) begin
      logic e;
      @(negedge clk);
      if (i <= 40) begin
        if (i <= 4)       e = 1'b0;
        else if (i <= 36) e = b55[(i-5)/4];
        else              e = 1'b1;
        check($sformatf("f55_c%0d", i), {31'h0, tx_o},
              {31'h0, e});
      end
      if (i == 40) begin
        rd(A_ST, v); check("f55_busy", {31'h0, v[0]}, 32'h1);
      end
      if (i == 41) begin
        rd(A_ST, v); check("f55_done", v, 32'h4);
      end
    end

    // Overflow and W1C.
    reset_dut();
    for (int k = 0; k < 5; k++) wr(A_TX, 4'h1, 32'h10 + k);
    rd(A_ST, v); check("ovf_status", v, 32'h62);
    wr(A_ST, 4'h1, 32'h40);
    rd(A_ST, v); check("ovf_w1c", v, 32'h22);

    // Push in the same cycle as the pop of a full FIFO.
    wr(A_BD, 4'h3, 32'd2);
    wr(A_CT, 4'h1, 32'h1);
    wr(A_TX, 4'h1, 32'hA7);
    rd(A_ST, v); check("push_at_pop", v, 32'h23);

    // Interrupt only once the frame has finished.
    reset_dut();
    wr(A_BD, 4'h3, 32'd2);
    wr(A_TX, 4'h1, 32'h3C);
    check("irq_pre", {31'h0, irq_o}, 32'h0);
    wr(A_CT, 4'h1, 32'h3);
    hi = 0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (i <= 21) hi += int'(irq_o);
      if (i == 21) begin
        rd(A_ST, v); check("irq_idle_status", v, 32'h4);
      end
      if (i == 22) check("irq_set", {31'h0, irq_o}, 32'h1);
    end
    check("irq_low_in_frame", hi, 0);

    // Divisor change mid-bit and tx_en cleared mid-frame.
    reset_dut();
    wr(A_BD, 4'h3, 32'd4);
    wr(A_TX, 4'h1, 32'h01);
    wr(A_TX, 4'h1, 32'h77);
    wr(A_CT, 4'h1, 32'h1);
    hi = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      idle();
      if (i == 4) check("dv_start", {31'h0, tx_o}, 32'h0);
      if (i == 5) check("dv_b0a", {31'h0, tx_o}, 32'h1);
      if (i == 6) check("dv_b0b", {31'h0, tx_o}, 32'h1);
      if (i == 7) check("dv_b1", {31'h0, tx_o}, 32'h0);
      if (i >= 21) hi += int'(tx_o);
      if (i == 22) begin
        rd(A_ST, v); check("dv_stop_busy", v, 32'h9);
      end
      if (i == 23) begin
        rd(A_ST, v); check("dv_end", v, 32'h8);
      end
      if (i == 30) begin
        rd(A_ST, v); check("no_pop_after_clear", v, 32'h8);
      end
      if (i == 2) drive(1'b1, 1'b1, A_BD, 4'h3, 32'd2);
      if (i == 3) drive(1'b1, 1'b1, A_CT, 4'h1, 32'h0);
    end
    check("idle_after_clear", hi, 10);

    // Reset in the middle of a frame.
    reset_dut();
    wr(A_BD, 4'h3, 32'd4);
    wr(A_TX, 4'h1, 32'h00);
    wr(A_TX, 4'h1, 32'h00);
    wr(A_CT, 4'h1, 32'h1);
    repeat (8) @(negedge clk);
    check("mr_pre_tx", {31'h0, tx_o}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("mr_tx", {31'h0, tx_o}, 32'h1);
    rd(A_ST, v); check("mr_status", v, 32'h4);
    rst = 1'b1;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      hi += int'(tx_o);
    end
    check("mr_idle", hi, 20);

    rand_run(16'd0, 6);
    rand_run(16'd3, 6);
    rand_run(16'($urandom_range(1, 5)), 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
